// File: rtl/encrypt_stream_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : encrypt_stream_sequencer_pkg
// Brief  : Shared state encodings, latencies and helpers for the stream sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package encrypt_stream_sequencer_pkg;

  localparam int SRC_RD_LAT = 1;
  localparam int ENC_LAT    = 1;
  localparam int BYTE_W     = 8;
  localparam int SHIFT_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Rotating jobs advance the shift by one per byte, wrapping mod 8.
  function automatic logic [SHIFT_W-1:0] shift_for(input logic [SHIFT_W-1:0] base,
                                                   input logic               rot,
                                                   input logic [SHIFT_W-1:0] idx_lsb);
    return rot ? (base + idx_lsb) : base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/encrypt_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : encrypt_stream_sequencer_if
// Brief  : Control, source RAM, encrypter and destination RAM signal bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface encrypt_stream_sequencer_if #(
  parameter int ADDR_W = 10
);
  import encrypt_stream_sequencer_pkg::*;

  logic                  start;
  logic                  abort;
  logic [ADDR_W:0]       length;
  logic [BYTE_W-1:0]     key_in;
  logic [SHIFT_W-1:0]    shift_in;
  logic                  rotate_en;

  logic [ADDR_W-1:0]     src_addr;
  logic                  src_rd_en;
  logic [BYTE_W-1:0]     src_rd_data;

  logic [BYTE_W-1:0]     enc_key;
  logic [SHIFT_W-1:0]    enc_shift;
  logic [BYTE_W-1:0]     enc_din;
  logic                  enc_start_reset;
  logic                  enc_xor_enable;
  logic                  enc_improved_en;
  logic                  enc_last_data;
  logic [BYTE_W-1:0]     enc_dout;
  logic                  enc_led_complete;

  logic [ADDR_W-1:0]     dst_addr;
  logic                  dst_wr_en;
  logic [BYTE_W-1:0]     dst_wr_data;

  logic                  busy;
  logic                  done;
  logic [ADDR_W:0]       byte_count;

  modport slave (
    input  start, abort, length, key_in, shift_in, rotate_en,
    input  src_rd_data, enc_dout, enc_led_complete,
    output src_addr, src_rd_en,
    output enc_key, enc_shift, enc_din, enc_start_reset, enc_xor_enable,
    output enc_improved_en, enc_last_data,
    output dst_addr, dst_wr_en, dst_wr_data,
    output busy, done, byte_count
  );

  modport master (
    output start, abort, length, key_in, shift_in, rotate_en,
    output src_rd_data, enc_dout, enc_led_complete,
    input  src_addr, src_rd_en,
    input  enc_key, enc_shift, enc_din, enc_start_reset, enc_xor_enable,
    input  enc_improved_en, enc_last_data,
    input  dst_addr, dst_wr_en, dst_wr_data,
    input  busy, done, byte_count
  );

endinterface
`default_nettype wire

// File: rtl/encrypt_stream_sequencer_enc_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module : encrypt_stream_sequencer_enc_valid_pipe
// Brief  : Valid/index/last shift register tracking each byte from read to write.
// Rev    : 1.0  initial release
// ============================================================================
module encrypt_stream_sequencer_enc_valid_pipe
  import encrypt_stream_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic              last_i,
  output logic              xor_valid_o,
  output logic              xor_last_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_idx_o
);

  localparam int DEPTH = SRC_RD_LAT + ENC_LAT;

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] idx_q [DEPTH];
  logic              last_q;

  // Flush only kills valid/last; stale indices are harmless without valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        idx_q[s] <= '0;
      end
    end else begin
      if (flush_i) begin
        valid_q <= '0;
      end else begin
        valid_q <= {valid_q[DEPTH-2:0], valid_i};
      end
      last_q   <= ~flush_i & valid_i & last_i;
      idx_q[0] <= idx_i;
      for (int s = DEPTH - 1; s > 0; s--) begin
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  assign xor_valid_o = valid_q[SRC_RD_LAT-1];
  assign xor_last_o  = last_q;
  assign wr_valid_o  = valid_q[DEPTH-1];
  assign wr_idx_o    = idx_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/encrypt_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module : encrypt_stream_sequencer
// Brief  : Streams a source RAM buffer through the xor encrypter into destination RAM.
// Rev    : 1.0  initial release
// ============================================================================
module encrypt_stream_sequencer
  import encrypt_stream_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  encrypt_stream_sequencer_if.slave seq_if
);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    idx_q, idx_d;
  logic [ADDR_W:0]    byte_count_q, byte_count_d;
  logic [ADDR_W:0]    len_q;
  logic [BYTE_W-1:0]  key_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               rot_q;

  logic               take_start;
  logic               last_rd;
  logic               rd_en;
  logic               start_reset;
  logic               xor_valid;
  logic               xor_last;
  logic               wr_valid;
  logic [ADDR_W-1:0]  wr_idx;
  logic               unused_led_complete;

  assign take_start = seq_if.start & ~seq_if.abort
                    & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign last_rd    = (idx_q == (len_q - 1'b1));

  // Job parameters are frozen at start so mid-job input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      rot_q   <= 1'b0;
    end else if (take_start) begin
      key_q   <= seq_if.key_in;
      shift_q <= seq_if.shift_in;
      len_q   <= seq_if.length;
      rot_q   <= seq_if.rotate_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    byte_count_d = byte_count_q;
    rd_en        = 1'b0;
    start_reset  = 1'b0;
    if (seq_if.abort) begin
      state_d     = ST_IDLE;
      start_reset = 1'b1;
    end else begin
      if (wr_valid) begin
        byte_count_d = byte_count_q + 1'b1;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (seq_if.start) begin
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          start_reset  = 1'b1;
          idx_d        = '0;
          byte_count_d = '0;
          state_d      = (len_q == '0) ? ST_DONE : ST_STREAM;
        end
        ST_STREAM: begin
          rd_en = 1'b1;
          idx_d = idx_q + 1'b1;
          if (last_rd) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last byte has left the xor stage once stage 1 is empty.
          if (!xor_valid) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  encrypt_stream_sequencer_enc_valid_pipe #(
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (seq_if.abort),
    .valid_i     (rd_en),
    .idx_i       (idx_q[ADDR_W-1:0]),
    .last_i      (last_rd),
    .xor_valid_o (xor_valid),
    .xor_last_o  (xor_last),
    .wr_valid_o  (wr_valid),
    .wr_idx_o    (wr_idx)
  );

  assign seq_if.src_addr        = idx_q[ADDR_W-1:0];
  assign seq_if.src_rd_en       = rd_en;
  assign seq_if.enc_key         = key_q;
  assign seq_if.enc_shift       = shift_for(shift_q, rot_q, idx_q[SHIFT_W-1:0]);
  assign seq_if.enc_din         = seq_if.src_rd_data;
  assign seq_if.enc_start_reset = start_reset;
  assign seq_if.enc_xor_enable  = xor_valid & ~seq_if.abort;
  assign seq_if.enc_improved_en = 1'b0;
  assign seq_if.enc_last_data   = xor_valid & xor_last & ~seq_if.abort;
  assign seq_if.dst_addr        = wr_idx;
  assign seq_if.dst_wr_en       = wr_valid & ~seq_if.abort;
  assign seq_if.dst_wr_data     = seq_if.enc_dout;
  assign seq_if.busy            = (state_q == ST_CLEAR) | (state_q == ST_STREAM)
                                | (state_q == ST_DRAIN);
  assign seq_if.done            = (state_q == ST_DONE);
  assign seq_if.byte_count      = byte_count_q;

  assign unused_led_complete    = seq_if.enc_led_complete;

endmodule
`default_nettype wire
